demux_l2: RTL

DEMUX_L2 -- requirements
Module: demux_l2

---
 rtl/demux_l2.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/demux_l2.sv
// demux_l2: 1-to-4 lane de-serializer with valid-bit alignment and loss detection.
// A serial stream of WIDTH-bit words (MSB = valid) is cut into frames of four
// consecutive words. Alignment is acquired on the first valid word seen while
// idle and dropped after LOSS_FRAMES consecutive frames with no valid word.
module demux_l2 #(
  parameter int WIDTH       = 9,
  parameter int LOSS_FRAMES = 2
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] data0,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic             frame_valid,
  output logic             aligned,
  output logic [1:0]       slot
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Loss limit is compared against the 4-bit counter, so keep it in that width.
  localparam logic [3:0] LOSS_LIMIT = 4'(LOSS_FRAMES);

  state_t           state;
  state_t           state_next;
  logic [1:0]       slot_cnt;
  logic [1:0]       slot_next;
  logic [3:0]       loss_cnt;
  logic [3:0]       loss_next;
  logic             frame_has_valid;
  logic             has_valid_next;
  logic             frame_done;
  logic             frame_any_valid;
  logic             in_valid;
  logic [WIDTH-1:0] shadow0;
  logic [WIDTH-1:0] shadow1;
  logic [WIDTH-1:0] shadow2;

  assign in_valid = in_data[WIDTH-1];
  assign slot     = slot_cnt;

  // Next-state, slot, loss and per-frame valid tracking; frame_done marks the slot-3 word.
  always_comb begin
    state_next      = state;
    slot_next       = slot_cnt;
    loss_next       = loss_cnt;
    has_valid_next  = frame_has_valid;
    frame_done      = 1'b0;
    frame_any_valid = frame_has_valid | in_valid;

    case (state)
      IDLE: begin
        slot_next = 2'd0;
        if (in_valid) begin
          state_next     = RUN;
          slot_next      = 2'd1;
          has_valid_next = 1'b1;
        end
      end

      RUN: begin
        slot_next      = slot_cnt + 2'd1;
        has_valid_next = frame_has_valid | in_valid;
        if (slot_cnt == 2'd3) begin
          frame_done     = 1'b1;
          has_valid_next = 1'b0;
          if (frame_any_valid) begin
            loss_next = 4'd0;
          end else if ((loss_cnt + 4'd1) == LOSS_LIMIT) begin
            loss_next  = 4'd0;
            state_next = IDLE;
            slot_next  = 2'd0;
          end else begin
            loss_next = loss_cnt + 4'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        slot_next  = 2'd0;
      end
    endcase
  end

  // FSM state register; aligned is registered alongside so it tracks state exactly.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state   <= IDLE;
      aligned <= 1'b0;
    end else begin
      state   <= state_next;
      aligned <= (state_next == RUN);
    end
  end

  // Slot counter, loss counter and "frame so far contained a valid word" flag.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      slot_cnt        <= 2'd0;
      loss_cnt        <= 4'd0;
      frame_has_valid <= 1'b0;
    end else begin
      slot_cnt        <= slot_next;
      loss_cnt        <= loss_next;
      frame_has_valid <= has_valid_next;
    end
  end

  // Shadow capture of lanes 0..2; the IDLE->RUN word is lane 0 of the new frame.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      shadow0 <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        shadow0 <= in_data;
      end
    end else begin
      case (slot_cnt)
        2'd0:    shadow0 <= in_data;
        2'd1:    shadow1 <= in_data;
        2'd2:    shadow2 <= in_data;
        default: ;
      endcase
    end
  end

  // Atomic output load at frame end, with a one-cycle frame_valid strobe.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      data0       <= '0;
      data1       <= '0;
      data2       <= '0;
      data3       <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        data0 <= shadow0;
        data1 <= shadow1;
        data2 <= shadow2;
        data3 <= in_data;
      end
    end
  end

endmodule
